// File: rtl/exc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// exc_irq_ctrl
//
// Sequential exception/interrupt controller for the LEGv8 pipeline. It replaces
// the single ExtIRQ line with N_IRQ maskable interrupt channels and arbitrates
// them against invalid-opcode faults reported by the decoder for the
// instruction at commit.
//
// Interrupt edges are captured into pending bits. A trigger seen at commit
// produces a one-cycle redirect pulse (exc) in the following cycle.
// ELR/ESR/irq_id are then held until the next exception is taken.
//
// Optional feature macro: IRQ_SYNC_EN
//   defined     : irq_in passes a 2-flop synchroniser before edge detection
//                 (two extra cycles of irq -> pending latency).
//   not defined : irq_in is assumed synchronous to clk.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   irq_in        external interrupt requests (level, rising edge sets pending)
//   mask_we       write the mask register this cycle
//   mask_wdata    new mask value (1 = channel enabled)
//   commit_valid  a valid instruction is at commit this cycle
//   commit_pc     PC of the committing instruction
//   not_an_instr  decoder invalid-opcode flag for the committing instruction
//   eret          ERET committing (qualified by commit_valid)
//   exc           one-cycle pulse: flush pipeline, PC <- exc_vector
//   exc_vector    constant exception vector VEC_ADDR
//   elr           saved return PC
//   esr           saved exception status (0001 = IRQ, 0010 = invalid opcode)
//   irq_id        channel taken (meaningful when esr = 0001)
//   irq_ack       one-hot acknowledge, coincident with exc
//   pending       pending interrupt register
//   in_handler    controller is in its handler state
//   halted        double fault, core must stop
// -----------------------------------------------------------------------------
module exc_irq_ctrl #(
    parameter int                N_IRQ     = 4,
    parameter int                PC_W      = 64,
    parameter int                ESTATUS_W = 4,
    parameter logic [PC_W-1:0]   VEC_ADDR  = 64'h0000_0000_0000_00D8,
    localparam int               IRQ_ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IRQ-1:0]      irq_in,
    input  logic                  mask_we,
    input  logic [N_IRQ-1:0]      mask_wdata,
    input  logic                  commit_valid,
    input  logic [PC_W-1:0]       commit_pc,
    input  logic                  not_an_instr,
    input  logic                  eret,
    output logic                  exc,
    output logic [PC_W-1:0]       exc_vector,
    output logic [PC_W-1:0]       elr,
    output logic [ESTATUS_W-1:0]  esr,
    output logic [IRQ_ID_W-1:0]   irq_id,
    output logic [N_IRQ-1:0]      irq_ack,
    output logic [N_IRQ-1:0]      pending,
    output logic                  in_handler,
    output logic                  halted
);

    localparam logic [ESTATUS_W-1:0] ESR_IRQ   = ESTATUS_W'(1);
    localparam logic [ESTATUS_W-1:0] ESR_UNDEF = ESTATUS_W'(2);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_TAKE,
        ST_HANDLER,
        ST_FAULT
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [N_IRQ-1:0]      irq_s;
    logic [N_IRQ-1:0]      irq_q;
    logic [N_IRQ-1:0]      irq_edge;
    logic [N_IRQ-1:0]      mask;
    logic [N_IRQ-1:0]      eligible;
    logic [IRQ_ID_W-1:0]   winner;
    logic                  take_fault;
    logic                  take_irq;

    assign exc_vector = VEC_ADDR;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1;
    logic [N_IRQ-1:0] sync2;

    // Two-flop synchroniser for asynchronous interrupt sources.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq_in;
`endif

    assign irq_edge = irq_s & ~irq_q;
    assign eligible = pending & mask;

    // Edge detection, mask register and pending bits. A new edge on the same
    // cycle as its acknowledge keeps the pending bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q   <= '0;
            mask    <= '1;
            pending <= '0;
        end else begin
            irq_q   <= irq_s;
            pending <= (pending & ~irq_ack) | irq_edge;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    // Fixed priority among eligible channels: the lowest index wins.
    always_comb begin
        winner = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                winner = IRQ_ID_W'(k);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs. Exceptions are only taken while an
    // instruction is committing, so ELR always holds a real PC. An invalid
    // opcode outranks any interrupt. In the handler, a fault beats ERET.
    always_comb begin
        state_d    = state_q;
        exc        = 1'b0;
        in_handler = 1'b0;
        halted     = 1'b0;
        take_fault = 1'b0;
        take_irq   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (commit_valid && not_an_instr) begin
                    take_fault = 1'b1;
                    state_d    = ST_TAKE;
                end else if (commit_valid && (|eligible)) begin
                    take_irq = 1'b1;
                    state_d  = ST_TAKE;
                end
            end
            ST_TAKE: begin
                exc     = 1'b1;
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                in_handler = 1'b1;
                if (commit_valid && not_an_instr) begin
                    state_d = ST_FAULT;
                end else if (commit_valid && eret) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // The acknowledge goes only to the channel that was taken, and only while
    // exc is high; a fault exception acknowledges nothing.
    always_comb begin
        irq_ack = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            irq_ack[k] = exc && (esr == ESR_IRQ) && (irq_id == IRQ_ID_W'(k));
        end
    end

    // Exception context capture. irq_id is left untouched by a fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elr    <= '0;
            esr    <= '0;
            irq_id <= '0;
        end else if (take_fault) begin
            elr <= commit_pc;
            esr <= ESR_UNDEF;
        end else if (take_irq) begin
            elr    <= commit_pc;
            esr    <= ESR_IRQ;
            irq_id <= winner;
        end
    end

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_irq_ctrl
//
// Self-checking bench for exc_irq_ctrl. Directed scenarios check against
// constants. A randomized phase checks against a behavioural model that tracks
// the controller as a few flags and an input history.
// -----------------------------------------------------------------------------
module tb_exc_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq_in = '0;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_wdata = '0;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = '0;
    logic        not_an_instr = 1'b0;
    logic        eret = 1'b0;
    logic        exc;
    logic [63:0] exc_vector;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic [1:0]  irq_id;
    logic [3:0]  irq_ack;
    logic [3:0]  pending;
    logic        in_handler;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [3:0]  hist [4];
    logic [3:0]  m_pending;
    logic [3:0]  m_mask;
    logic        m_exc;
    logic        m_handler;
    logic        m_halted;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;
    int          m_id;

    exc_irq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .not_an_instr (not_an_instr),
        .eret         (eret),
        .exc          (exc),
        .exc_vector   (exc_vector),
        .elr          (elr),
        .esr          (esr),
        .irq_id       (irq_id),
        .irq_ack      (irq_ack),
        .pending      (pending),
        .in_handler   (in_handler),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = '0;
        m_pending = '0;
        m_mask    = 4'hF;
        m_exc     = 1'b0;
        m_handler = 1'b0;
        m_halted  = 1'b0;
        m_elr     = '0;
        m_esr     = '0;
        m_id      = 0;
    endtask

    // Applies one clock edge to the model using the inputs present at the edge.
    task automatic model_step();
        logic [3:0] rise;
        logic [3:0] ack;
        logic [3:0] elig;
        int         k;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = irq_in;
        rise = hist[SYNC_D] & ~hist[SYNC_D + 1];
        ack  = (m_exc && m_esr == 4'd1) ? 4'(1 << m_id) : 4'b0000;
        elig = m_pending & m_mask;
        if (m_halted) begin
        end else if (m_exc) begin
            m_exc     = 1'b0;
            m_handler = 1'b1;
        end else if (m_handler) begin
            if (commit_valid && not_an_instr) begin
                m_handler = 1'b0;
                m_halted  = 1'b1;
            end else if (commit_valid && eret) begin
                m_handler = 1'b0;
            end
        end else if (commit_valid) begin
            if (not_an_instr) begin
                m_exc = 1'b1;
                m_elr = commit_pc;
                m_esr = 4'd2;
            end else if (elig != 4'b0000) begin
                k = 0;
                while (!elig[k]) k++;
                m_exc = 1'b1;
                m_elr = commit_pc;
                m_esr = 4'd1;
                m_id  = k;
            end
        end
        if (mask_we) m_mask = mask_wdata;
        m_pending = (m_pending & ~ack) | rise;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        model_reset();
        repeat (cycles) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic leave_handler();
        commit_valid = 1'b1;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic test_reset();
        irq_in = '0;
        do_reset(3);
        n_checks++; if (exc !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_exc: got %b expected 0", exc); end
        n_checks++; if (irq_ack !== 4'b0) begin n_errors++; $display("[TB] FAIL rst_ack: got %b expected 0000", irq_ack); end
        n_checks++; if (pending !== 4'b0) begin n_errors++; $display("[TB] FAIL rst_pending: got %b expected 0000", pending); end
        n_checks++; if (elr !== 64'h0) begin n_errors++; $display("[TB] FAIL rst_elr: got %h expected 0", elr); end
        n_checks++; if (esr !== 4'h0) begin n_errors++; $display("[TB] FAIL rst_esr: got %h expected 0", esr); end
        n_checks++; if (irq_id !== 2'd0) begin n_errors++; $display("[TB] FAIL rst_irq_id: got %0d expected 0", irq_id); end
        n_checks++; if (in_handler !== 1'b0 || halted !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_flags: got %b%b expected 00", in_handler, halted); end
        n_checks++; if (exc_vector !== 64'hD8) begin n_errors++; $display("[TB] FAIL exc_vector: got %h expected d8", exc_vector); end
        for (int i = 0; i < 6; i++) begin
            commit_valid = 1'(i % 2);
            commit_pc = 64'h10 + 64'(4 * i);
            tick();
            n_checks++; if (exc !== 1'b0) begin n_errors++; $display("[TB] FAIL idle_exc: got %b expected 0 at cycle %0d", exc, i); end
        end
        commit_valid = 1'b0;
    endtask

    task automatic test_single_irq();
        int cyc;
        irq_in = 4'b0100;
        commit_valid = 1'b1;
        commit_pc = 64'h40;
        cyc = 0;
        do begin tick(); cyc++; end while (exc !== 1'b1 && cyc < 10);
        n_checks++; if (exc !== 1'b1) begin n_errors++; $display("[TB] FAIL t2_timeout: got exc %b expected 1 within 10 cycles", exc); end
        n_checks++; if (cyc != 2 + SYNC_D) begin n_errors++; $display("[TB] FAIL t2_latency: got %0d cycles expected %0d", cyc, 2 + SYNC_D); end
        n_checks++; if (irq_ack !== 4'b0100) begin n_errors++; $display("[TB] FAIL t2_ack: got %b expected 0100", irq_ack); end
        n_checks++; if (elr !== 64'h40) begin n_errors++; $display("[TB] FAIL t2_elr: got %h expected 40", elr); end
        n_checks++; if (esr !== 4'b0001) begin n_errors++; $display("[TB] FAIL t2_esr: got %b expected 0001", esr); end
        n_checks++; if (irq_id !== 2'd2) begin n_errors++; $display("[TB] FAIL t2_irq_id: got %0d expected 2", irq_id); end
        commit_valid = 1'b0;
        tick();
        n_checks++; if (exc !== 1'b0) begin n_errors++; $display("[TB] FAIL t2_pulse_len: got exc %b expected 0", exc); end
        n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("[TB] FAIL t2_pending: got %b expected 0000", pending); end
        n_checks++; if (in_handler !== 1'b1) begin n_errors++; $display("[TB] FAIL t2_in_handler: got %b expected 1", in_handler); end
        leave_handler();
        n_checks++; if (in_handler !== 1'b0 || elr !== 64'h40) begin n_errors++; $display("[TB] FAIL t2_eret: got in_handler %b elr %h expected 0 40", in_handler, elr); end
        irq_in = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        irq_in = 4'b1010;
        commit_valid = 1'b1;
        commit_pc = 64'h100;
        cyc = 0;
        do begin tick(); cyc++; end while (exc !== 1'b1 && cyc < 10);
        n_checks++; if (exc !== 1'b1 || irq_id !== 2'd1 || irq_ack !== 4'b0010) begin n_errors++; $display("[TB] FAIL t3_first: got exc %b id %0d ack %b expected 1 1 0010", exc, irq_id, irq_ack); end
        commit_pc = 64'h104;
        tick();
        n_checks++; if (pending !== 4'b1000) begin n_errors++; $display("[TB] FAIL t3_pending: got %b expected 1000", pending); end
        tick();
        n_checks++; if (exc !== 1'b0 || in_handler !== 1'b1) begin n_errors++; $display("[TB] FAIL t3_no_nest: got exc %b in_handler %b expected 0 1", exc, in_handler); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (exc !== 1'b0 || in_handler !== 1'b0) begin n_errors++; $display("[TB] FAIL t3_eret: got exc %b in_handler %b expected 0 0", exc, in_handler); end
        commit_pc = 64'h108;
        tick();
        n_checks++; if (exc !== 1'b1 || irq_id !== 2'd3 || irq_ack !== 4'b1000) begin n_errors++; $display("[TB] FAIL t3_second: got exc %b id %0d ack %b expected 1 3 1000", exc, irq_id, irq_ack); end
        n_checks++; if (elr !== 64'h108) begin n_errors++; $display("[TB] FAIL t3_elr: got %h expected 108", elr); end
        commit_valid = 1'b0;
        tick();
        leave_handler();
        irq_in = '0;
        tick();
    endtask

    task automatic test_mask();
        int cyc;
        mask_we = 1'b1;
        mask_wdata = 4'b1110;
        commit_valid = 1'b1;
        commit_pc = 64'h200;
        tick();
        mask_we = 1'b0;
        irq_in = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (exc !== 1'b0) begin n_errors++; $display("[TB] FAIL t4_masked_exc: got %b expected 0 at cycle %0d", exc, i); end
        end
        n_checks++; if (pending !== 4'b0001) begin n_errors++; $display("[TB] FAIL t4_pending: got %b expected 0001", pending); end
        mask_we = 1'b1;
        mask_wdata = 4'hF;
        tick();
        mask_we = 1'b0;
        cyc = 0;
        while (exc !== 1'b1 && cyc < 5) begin tick(); cyc++; end
        n_checks++; if (exc !== 1'b1 || irq_id !== 2'd0 || irq_ack !== 4'b0001) begin n_errors++; $display("[TB] FAIL t4_unmask: got exc %b id %0d ack %b expected 1 0 0001", exc, irq_id, irq_ack); end
        commit_valid = 1'b0;
        tick();
        leave_handler();
        irq_in = '0;
        tick();
    endtask

    task automatic test_fault_priority();
        int cyc;
        irq_in = 4'b0001;
        commit_valid = 1'b1;
        not_an_instr = 1'b1;
        commit_pc = 64'h80;
        tick();
        not_an_instr = 1'b0;
        commit_valid = 1'b0;
        n_checks++; if (exc !== 1'b1 || esr !== 4'b0010) begin n_errors++; $display("[TB] FAIL t5_fault: got exc %b esr %b expected 1 0010", exc, esr); end
        n_checks++; if (elr !== 64'h80) begin n_errors++; $display("[TB] FAIL t5_elr: got %h expected 80", elr); end
        n_checks++; if (irq_ack !== 4'b0000) begin n_errors++; $display("[TB] FAIL t5_ack: got %b expected 0000", irq_ack); end
        repeat (4) tick();
        n_checks++; if (pending !== 4'b0001 || in_handler !== 1'b1) begin n_errors++; $display("[TB] FAIL t5_still_pending: got %b in_handler %b expected 0001 1", pending, in_handler); end
        leave_handler();
        commit_valid = 1'b1;
        commit_pc = 64'h84;
        cyc = 0;
        while (exc !== 1'b1 && cyc < 5) begin tick(); cyc++; end
        n_checks++; if (exc !== 1'b1 || irq_id !== 2'd0 || esr !== 4'b0001) begin n_errors++; $display("[TB] FAIL t5_irq_after: got exc %b id %0d esr %b expected 1 0 0001", exc, irq_id, esr); end
        commit_valid = 1'b0;
        tick();
        leave_handler();
        irq_in = '0;
        tick();
    endtask

    task automatic test_double_fault();
        int cyc;
        irq_in = 4'b0100;
        commit_valid = 1'b1;
        commit_pc = 64'h300;
        cyc = 0;
        while (exc !== 1'b1 && cyc < 10) begin tick(); cyc++; end
        tick();
        not_an_instr = 1'b1;
        eret = 1'b1;
        tick();
        not_an_instr = 1'b0;
        eret = 1'b0;
        n_checks++; if (halted !== 1'b1 || exc !== 1'b0 || in_handler !== 1'b0) begin n_errors++; $display("[TB] FAIL t6_halt: got halted %b exc %b in_handler %b expected 1 0 0", halted, exc, in_handler); end
        for (int i = 0; i < 8; i++) begin
            irq_in = 4'($urandom);
            commit_valid = 1'($urandom);
            eret = 1'($urandom);
            not_an_instr = 1'($urandom);
            tick();
            n_checks++; if (halted !== 1'b1 || exc !== 1'b0) begin n_errors++; $display("[TB] FAIL t6_stays_halted: got halted %b exc %b expected 1 0", halted, exc); end
        end
        irq_in = '0;
        commit_valid = 1'b0;
        eret = 1'b0;
        not_an_instr = 1'b0;
        do_reset(2);
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("[TB] FAIL t6_reset: got halted %b expected 0", halted); end
    endtask

    task automatic test_reset_mid_take();
        int cyc;
        irq_in = 4'b0011;
        commit_valid = 1'b1;
        commit_pc = 64'h400;
        cyc = 0;
        while (exc !== 1'b1 && cyc < 10) begin tick(); cyc++; end
        n_checks++; if (exc !== 1'b1) begin n_errors++; $display("[TB] FAIL rmt_take: got exc %b expected 1", exc); end
        irq_in = '0;
        commit_valid = 1'b0;
        do_reset(1);
        n_checks++; if (exc !== 1'b0 || pending !== 4'b0000 || elr !== 64'h0) begin n_errors++; $display("[TB] FAIL rmt_cleared: got exc %b pending %b elr %h expected 0 0000 0", exc, pending, elr); end
        tick();
        n_checks++; if (in_handler !== 1'b0 || exc !== 1'b0) begin n_errors++; $display("[TB] FAIL rmt_run: got in_handler %b exc %b expected 0 0", in_handler, exc); end
    endtask

    task automatic test_random(input int n);
        logic [3:0] exp_ack;
        for (int i = 0; i < n; i++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || (i % 150 == 149)) begin
                do_reset(2);
                n_checks++; if (pending !== 4'b0 || in_handler !== 1'b0 || exc !== 1'b0 || halted !== 1'b0) begin n_errors++; $display("[TB] FAIL rnd_reset: got pending %b flags %b%b%b expected 0000 000", pending, exc, in_handler, halted); end
            end
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 99) < 15) irq_in[k] = ~irq_in[k];
            commit_valid = ($urandom_range(0, 99) < 60);
            not_an_instr = ($urandom_range(0, 99) < 4);
            eret = ($urandom_range(0, 99) < 30);
            mask_we = ($urandom_range(0, 99) < 6);
            mask_wdata = 4'($urandom);
            commit_pc = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            tick();
            exp_ack = (m_exc && m_esr == 4'd1) ? 4'(1 << m_id) : 4'b0000;
            n_checks++; if (exc !== m_exc) begin n_errors++; $display("[TB] FAIL rnd_exc: got %b expected %b at step %0d", exc, m_exc, i); end
            n_checks++; if (irq_ack !== exp_ack) begin n_errors++; $display("[TB] FAIL rnd_ack: got %b expected %b at step %0d", irq_ack, exp_ack, i); end
            n_checks++; if (pending !== m_pending) begin n_errors++; $display("[TB] FAIL rnd_pending: got %b expected %b at step %0d", pending, m_pending, i); end
            n_checks++; if (elr !== m_elr) begin n_errors++; $display("[TB] FAIL rnd_elr: got %h expected %h at step %0d", elr, m_elr, i); end
            n_checks++; if (esr !== m_esr) begin n_errors++; $display("[TB] FAIL rnd_esr: got %b expected %b at step %0d", esr, m_esr, i); end
            if (m_esr == 4'd1) begin
                n_checks++; if (irq_id !== 2'(m_id)) begin n_errors++; $display("[TB] FAIL rnd_irq_id: got %0d expected %0d at step %0d", irq_id, m_id, i); end
            end
            n_checks++; if (in_handler !== m_handler) begin n_errors++; $display("[TB] FAIL rnd_in_handler: got %b expected %b at step %0d", in_handler, m_handler, i); end
            n_checks++; if (halted !== m_halted) begin n_errors++; $display("[TB] FAIL rnd_halted: got %b expected %b at step %0d", halted, m_halted, i); end
        end
        mask_we = 1'b0;
        commit_valid = 1'b0;
        not_an_instr = 1'b0;
        eret = 1'b0;
    endtask

    initial begin
        $display("[TB] starting exc_irq_ctrl bench (sync delay %0d)", SYNC_D);
        test_reset();
        test_single_irq();
        test_back_to_back();
        test_mask();
        test_fault_priority();
        test_double_fault();
        test_reset_mid_take();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
